// File: rtl/rtio_ts_pkg.sv
// Shared constants and the default time-base type for the RTIO timestamp counter.
package rtio_ts_pkg;

  localparam int TS_W_DEF        = 64;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int N_CMP_DEF       = 4;

  typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/rtio_timestamp_counter_cdc_sync_bit.sv
// Single-bit flop-chain synchroniser for asynchronous levels entering the clk domain.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rtio_timestamp_counter.sv
// Free-running timestamp counter with jump-load, sticky wrap flag, one-shot
// compare channels and a valid/ready snapshot port.
module rtio_timestamp_counter
  import rtio_ts_pkg::*;
#(
  parameter int CNT_W       = TS_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int N_CMP       = N_CMP_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   load,
  input  logic [CNT_W-1:0]       load_value,
  input  logic [N_CMP*CNT_W-1:0] cmp_value,
  input  logic [N_CMP-1:0]       cmp_arm,
  input  logic                   snap_req,
  input  logic                   snap_ready,
  output logic [CNT_W-1:0]       counter,
  output logic                   running,
  output logic                   wrapped,
  output logic [N_CMP-1:0]       cmp_armed,
  output logic [N_CMP-1:0]       cmp_hit,
  output logic                   snap_valid,
  output logic [CNT_W-1:0]       snap_value
);

  logic             w_start_s;
  logic             w_load_s;
  logic             w_load_pulse;
  logic             r_load_d;
  logic [CNT_W-1:0] r_counter;
  logic             r_wrapped;
  logic [N_CMP-1:0] r_armed;
  logic [N_CMP-1:0] r_hit;
  logic [N_CMP-1:0] w_match;
  logic             r_snap_valid;
  logic [CNT_W-1:0] r_snap_value;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk   (clk),
    .reset (reset),
    .i_d   (start),
    .o_q   (w_start_s)
  );

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk   (clk),
    .reset (reset),
    .i_d   (load),
    .o_q   (w_load_s)
  );

  // A held load level produces exactly one load on its synchronised rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_d <= 1'b0;
    end else begin
      r_load_d <= w_load_s;
    end
  end

  assign w_load_pulse = w_load_s & ~r_load_d;

  // Load outranks counting, and also clears a wrap that lands on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_counter <= '0;
      r_wrapped <= 1'b0;
    end else if (w_load_pulse) begin
      r_counter <= load_value;
      r_wrapped <= 1'b0;
    end else if (w_start_s) begin
      r_counter <= r_counter + 1'b1;
      if (&r_counter) begin
        r_wrapped <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CMP; g++) begin : g_cmp
    assign w_match[g] = (r_counter == cmp_value[g*CNT_W +: CNT_W]);
  end

  // An arm pulse takes precedence over a coincident match, so the hit lands one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed <= '0;
      r_hit   <= '0;
    end else begin
      for (int i = 0; i < N_CMP; i++) begin
        r_hit[i] <= 1'b0;
        if (cmp_arm[i]) begin
          r_armed[i] <= 1'b1;
        end else if (r_armed[i] && w_match[i]) begin
          r_hit[i]   <= 1'b1;
          r_armed[i] <= 1'b0;
        end
      end
    end
  end

  // Requests arriving while the holding register is full, including the accept cycle, are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_valid <= 1'b0;
      r_snap_value <= '0;
    end else if (r_snap_valid) begin
      if (snap_ready) begin
        r_snap_valid <= 1'b0;
      end
    end else if (snap_req) begin
      r_snap_valid <= 1'b1;
      r_snap_value <= r_counter;
    end
  end

  assign counter    = r_counter;
  assign running    = w_start_s;
  assign wrapped    = r_wrapped;
  assign cmp_armed  = r_armed;
  assign cmp_hit    = r_hit;
  assign snap_valid = r_snap_valid;
  assign snap_value = r_snap_value;

endmodule

// File: tb/tb_rtio_timestamp_counter.sv
// Directed self-checking bench for rtio_timestamp_counter with an 8-bit counter.
module tb_rtio_timestamp_counter;

  localparam int CW = 8;
  localparam int SS = 2;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            load;
  logic [CW-1:0]   loadValue;
  logic [NC*CW-1:0] cmpValue;
  logic [NC-1:0]   cmpArm;
  logic            snapReq;
  logic            snapReady;
  logic [CW-1:0]   counter;
  logic            running;
  logic            wrapped;
  logic [NC-1:0]   cmpArmed;
  logic [NC-1:0]   cmpHit;
  logic            snapValid;
  logic [CW-1:0]   snapValue;

  int errors = 0;
  int checks = 0;
  logic [NC-1:0] anyHit;

  rtio_timestamp_counter #(
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .N_CMP       (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load       (load),
    .load_value (loadValue),
    .cmp_value  (cmpValue),
    .cmp_arm    (cmpArm),
    .snap_req   (snapReq),
    .snap_ready (snapReady),
    .counter    (counter),
    .running    (running),
    .wrapped    (wrapped),
    .cmp_armed  (cmpArmed),
    .cmp_hit    (cmpHit),
    .snap_valid (snapValid),
    .snap_value (snapValue)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " counter"}, 64'(counter), 64'd0);
    checkOutput({tag, " running"}, 64'(running), 64'd0);
    checkOutput({tag, " wrapped"}, 64'(wrapped), 64'd0);
    checkOutput({tag, " armed"}, 64'(cmpArmed), 64'd0);
    checkOutput({tag, " hit"}, 64'(cmpHit), 64'd0);
    checkOutput({tag, " snap_valid"}, 64'(snapValid), 64'd0);
    checkOutput({tag, " snap_value"}, 64'(snapValue), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load = 1'b0; loadValue = '0;
    cmpValue = '0; cmpArm = '0; snapReq = 1'b0; snapReady = 1'b0;
    #1;
    applyStimulus();
    applyStimulus();
    checkResetState("reset");
    reset = 1'b0;

    $display("[TB] start/stop");
    start = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("run_rise", 64'(running), 64'd1);
    checkOutput("cnt_before_first_inc", 64'(counter), 64'd0);
    applyStimulus();
    checkOutput("cnt_first_inc", 64'(counter), 64'd1);
    repeat (7) applyStimulus();
    checkOutput("cnt_at_start_drop", 64'(counter), 64'd8);
    start = 1'b0;
    applyStimulus();
    checkOutput("run_still_high", 64'(running), 64'd1);
    checkOutput("cnt_drain1", 64'(counter), 64'd9);
    applyStimulus();
    checkOutput("run_fall", 64'(running), 64'd0);
    checkOutput("cnt_drain2", 64'(counter), 64'd10);
    repeat (3) applyStimulus();
    checkOutput("cnt_hold", 64'(counter), 64'd10);

    $display("[TB] load and wrap");
    start = 1'b1; load = 1'b1; loadValue = 8'hFE;
    applyStimulus();
    applyStimulus();
    checkOutput("cnt_pre_load", 64'(counter), 64'd10);
    applyStimulus();
    checkOutput("cnt_loaded_fe", 64'(counter), 64'hFE);
    applyStimulus();
    checkOutput("cnt_ff", 64'(counter), 64'hFF);
    checkOutput("wrap_not_yet", 64'(wrapped), 64'd0);
    applyStimulus();
    checkOutput("cnt_wrap0", 64'(counter), 64'd0);
    checkOutput("wrap_set", 64'(wrapped), 64'd1);
    load = 1'b0;
    repeat (3) applyStimulus();
    load = 1'b1; loadValue = 8'h10;
    applyStimulus();
    applyStimulus();
    checkOutput("cnt_pre_load2", 64'(counter), 64'd5);
    checkOutput("wrap_sticky", 64'(wrapped), 64'd1);
    applyStimulus();
    checkOutput("cnt_loaded_10", 64'(counter), 64'h10);
    checkOutput("wrap_cleared", 64'(wrapped), 64'd0);
    applyStimulus();
    checkOutput("cnt_held_load_counts", 64'(counter), 64'h11);

    $display("[TB] compare hit");
    load = 1'b0;
    repeat (3) applyStimulus();
    loadValue = 8'd0; load = 1'b1; cmpValue[2*CW +: CW] = 8'd25;
    repeat (3) applyStimulus();
    checkOutput("cnt_loaded_0", 64'(counter), 64'd0);
    cmpArm = 4'b0100;
    applyStimulus();
    cmpArm = 4'b0000;
    checkOutput("arm2", 64'(cmpArmed), 64'b0100);
    checkOutput("cnt_after_arm", 64'(counter), 64'd1);
    repeat (24) applyStimulus();
    checkOutput("cnt_25", 64'(counter), 64'd25);
    checkOutput("hit_not_yet", 64'(cmpHit), 64'd0);
    applyStimulus();
    checkOutput("hit2", 64'(cmpHit), 64'b0100);
    checkOutput("disarm2", 64'(cmpArmed), 64'd0);
    applyStimulus();
    checkOutput("hit2_one_cycle", 64'(cmpHit), 64'd0);
    anyHit = '0;
    repeat (256) begin
      applyStimulus();
      anyHit = anyHit | cmpHit;
    end
    checkOutput("no_rehit_after_wrap", 64'(anyHit), 64'd0);
    checkOutput("cnt_after_lap", 64'(counter), 64'd27);
    checkOutput("wrap_after_lap", 64'(wrapped), 64'd1);

    $display("[TB] arm vs match");
    start = 1'b0; load = 1'b0;
    repeat (3) applyStimulus();
    loadValue = 8'd40; load = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("cnt_stopped_40", 64'(counter), 64'd40);
    checkOutput("stopped", 64'(running), 64'd0);
    checkOutput("wrap_cleared_by_load", 64'(wrapped), 64'd0);
    cmpValue[0 +: CW] = 8'd40;
    cmpArm = 4'b0001;
    applyStimulus();
    cmpArm = 4'b0000;
    checkOutput("no_hit_on_arm_edge", 64'(cmpHit), 64'd0);
    checkOutput("arm0", 64'(cmpArmed), 64'b0001);
    applyStimulus();
    checkOutput("hit0", 64'(cmpHit), 64'b0001);
    checkOutput("disarm0", 64'(cmpArmed), 64'd0);
    applyStimulus();
    checkOutput("hit0_silent", 64'(cmpHit), 64'd0);

    $display("[TB] snapshot");
    start = 1'b1;
    for (int i = 0; i < 100 && counter != 8'd100; i++) applyStimulus();
    checkOutput("reach_100", 64'(counter), 64'd100);
    snapReq = 1'b1;
    applyStimulus();
    snapReq = 1'b0;
    checkOutput("snap_valid_rise", 64'(snapValid), 64'd1);
    checkOutput("snap_value_100", 64'(snapValue), 64'd100);
    applyStimulus();
    applyStimulus();
    checkOutput("cnt_103", 64'(counter), 64'd103);
    snapReq = 1'b1;
    applyStimulus();
    snapReq = 1'b0;
    checkOutput("snap_second_dropped", 64'(snapValue), 64'd100);
    applyStimulus();
    checkOutput("snap_valid_held", 64'(snapValid), 64'd1);
    snapReady = 1'b1; snapReq = 1'b1;
    applyStimulus();
    snapReady = 1'b0; snapReq = 1'b0;
    checkOutput("snap_accepted", 64'(snapValid), 64'd0);
    checkOutput("snap_value_kept", 64'(snapValue), 64'd100);
    applyStimulus();
    checkOutput("snap_accept_req_dropped", 64'(snapValid), 64'd0);

    $display("[TB] reset mid-operation");
    cmpValue[1*CW +: CW] = 8'd200;
    cmpArm = 4'b0010; snapReq = 1'b1;
    applyStimulus();
    cmpArm = 4'b0000; snapReq = 1'b0;
    checkOutput("pending_arm1", 64'(cmpArmed), 64'b0010);
    checkOutput("pending_snap", 64'(snapValid), 64'd1);
    reset = 1'b1;
    applyStimulus();
    checkResetState("midreset");
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
